// File: rtl/prm_edge_query_seq.sv
// prm_edge_query_seq: sweeps edge-query codes into a checker and packs mask results into words (optional hit counter: PRM_EDGE_HITCNT_EN)
module prm_edge_query_seq #(
  parameter int QW = 15,
  parameter int PW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [QW-1:0] base_i,
  input  logic [CW-1:0] count_i,
  output logic [QW-1:0] query_o,
  output logic          query_vld_o,
  input  logic          edge_mask_i,
  output logic [PW-1:0] word_o,
  output logic          word_vld_o,
  input  logic          word_rdy_i,
  output logic          word_last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] hit_cnt_o
);
  localparam int BW = $clog2(PW);
  typedef enum logic [1:0] {IDLE, ISSUE, EMIT, DONE} state_t;
  state_t        state_q, state_d;
  logic [QW-1:0] query_q, query_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] pack_q, pack_d;
  logic          start_ok, issue, emit_hs;
  assign start_ok = state_q == IDLE && start_i;
  assign issue    = state_q == ISSUE;
  assign emit_hs  = state_q == EMIT && word_rdy_i;
  // register stage for FSM and datapath; reset aborts any sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      query_q <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      query_q <= query_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      pack_q  <= pack_d;
    end
  end
  // next state: a word closes when it fills or the last query is sampled
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (count_i == '0) ? DONE : ISSUE;
      ISSUE:   if (bit_q == BW'(PW-1) || rem_q == CW'(1)) state_d = EMIT;
      EMIT:    if (word_rdy_i) state_d = (rem_q == '0) ? DONE : ISSUE;
      default: state_d = IDLE;
    endcase
  end
  // datapath: capture on start, sample/advance in ISSUE, clear pack on handshake
  always_comb begin
    query_d = start_ok ? base_i : issue ? query_q + QW'(1) : query_q;
    rem_d   = start_ok ? count_i : issue ? rem_q - CW'(1) : rem_q;
    bit_d   = (start_ok || emit_hs) ? '0 : issue ? bit_q + BW'(1) : bit_q;
    pack_d  = (start_ok || emit_hs) ? '0 : pack_q;
    if (issue) pack_d[bit_q] = edge_mask_i;
  end
  // state-decoded outputs
  always_comb begin
    query_o     = query_q;
    query_vld_o = issue;
    word_vld_o  = state_q == EMIT;
    word_o      = word_vld_o ? pack_q : '0;
    word_last_o = word_vld_o && rem_q == '0;
    busy_o      = state_q != IDLE;
    done_o      = state_q == DONE;
  end
`ifdef PRM_EDGE_HITCNT_EN
  logic [CW-1:0] hit_q, hit_d;
  // saturating count of sampled hits, cleared by each accepted start
  always_comb hit_d = start_ok ? '0 : (issue && edge_mask_i && hit_q != '1) ? hit_q + CW'(1) : hit_q;
  // hit counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else hit_q <= hit_d;
  end
  assign hit_cnt_o = hit_q;
`else
  assign hit_cnt_o = '0;
`endif
endmodule

// File: tb/tb_prm_edge_query_seq.sv
// tb_prm_edge_query_seq: directed self-checking bench for prm_edge_query_seq
module tb_prm_edge_query_seq;
  logic        clk = 0, rst_n = 0, start = 0, mask, rdy = 1;
  logic [14:0] base = '0, query;
  logic [15:0] count = '0, hit;
  logic [31:0] word;
  logic        qvld, wvld, wlast, busy, done;
  int          mode = 0, nchk = 0, nerr = 0;
  prm_edge_query_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_i(base), .count_i(count),
    .query_o(query), .query_vld_o(qvld), .edge_mask_i(mask), .word_o(word),
    .word_vld_o(wvld), .word_rdy_i(rdy), .word_last_o(wlast), .busy_o(busy),
    .done_o(done), .hit_cnt_o(hit)
  );
  always #5 clk = ~clk;
  always_comb mask = mode == 0 ? query == 15'h0012 : mode == 1 ? 1'b1 : mode == 2 ? query[0] : 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic hitchk(input string tag, input logic [15:0] n);
`ifdef PRM_EDGE_HITCNT_EN
    chk(tag, 32'(hit), 32'(n));
`else
    chk(tag, 32'(hit), 32'(n & 16'h0));
`endif
  endtask
  task automatic idle_chk(input string tag);
    chk(tag, {query, qvld, wvld, wlast, busy, done}, '0);
    chk({tag, "_word"}, word, '0);
  endtask
  task automatic go(input logic [14:0] b, input logic [15:0] c);
    base = b; count = c; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic sweep(input string tag, input logic [14:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_q"}, 32'(query), 32'(15'(b + 15'(i))));
      chk({tag, "_qvld"}, 32'(qvld), 1);
      @(negedge clk);
    end
  endtask
  task automatic word_chk(input string tag, input logic [31:0] w, input logic l);
    chk({tag, "_word"}, word, w);
    chk({tag, "_vld"}, {wvld, wlast, qvld}, {1'b1, l, 1'b0});
  endtask
  initial begin
    #1 idle_chk("reset");
    hitchk("reset_hit", 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); idle_chk("idle");
    // basic sweep
    mode = 0; go(15'h0010, 32);
    sweep("t1", 15'h0010, 32);
    word_chk("t1", 32'h4, 1);
    @(negedge clk);
    chk("t1_done", {done, busy, wvld}, 3'b110);
    hitchk("t1_hit", 1);
    @(negedge clk);
    chk("t1_idle", {done, busy}, 2'b00);
    hitchk("t1_hold", 1);
    // partial word
    mode = 1; go(15'h0000, 5);
    sweep("t2", 15'h0000, 5);
    word_chk("t2", 32'h1F, 1);
    @(negedge clk);
    chk("t2_done", 32'(done), 1);
    hitchk("t2_hit", 5);
    @(negedge clk);
    // backpressure and wrap
    mode = 2; rdy = 0; go(15'h7FF0, 40);
    sweep("t3a", 15'h7FF0, 32);
    for (int i = 0; i < 10; i++) begin
      word_chk("t3a_stall", 32'hAAAAAAAA, 0);
      @(negedge clk);
    end
    rdy = 1; @(negedge clk); rdy = 0;
    sweep("t3b", 15'h0010, 8);
    for (int i = 0; i < 10; i++) begin
      word_chk("t3b_stall", 32'h000000AA, 1);
      @(negedge clk);
    end
    rdy = 1; @(negedge clk);
    chk("t3_done", 32'(done), 1);
    hitchk("t3_hit", 20);
    @(negedge clk);
    // zero count; start coinciding with done is ignored
    go(15'h0123, 0);
    chk("t4_done", {done, wvld, qvld}, 3'b100);
    start = 1; count = 5;
    @(negedge clk);
    start = 0;
    chk("t4_ign_done_start", {busy, done, qvld}, 3'b000);
    // start during ISSUE is ignored
    mode = 1; go(15'h0100, 3);
    base = 15'h0555; count = 20; start = 1;
    chk("t4_iss_q", 32'(query), 32'h100);
    @(negedge clk);
    start = 0;
    sweep("t4", 15'h0101, 2);
    word_chk("t4", 32'h7, 1);
    @(negedge clk);
    chk("t4_done2", 32'(done), 1);
    hitchk("t4_hit", 3);
    @(negedge clk);
    // reset mid-sweep during EMIT
    rdy = 0; go(15'h0040, 64);
    sweep("t5", 15'h0040, 32);
    word_chk("t5_emit", 32'hFFFFFFFF, 0);
    rst_n = 0;
    #1 idle_chk("t5_rst");
    hitchk("t5_rst_hit", 0);
    @(negedge clk); rst_n = 1; rdy = 1;
    for (int i = 0; i < 3; i++) begin
      idle_chk("t5_after");
      @(negedge clk);
    end
    go(15'h0020, 2);
    sweep("t5n", 15'h0020, 2);
    word_chk("t5n", 32'h3, 1);
    @(negedge clk);
    chk("t5n_done", 32'(done), 1);
    hitchk("t5n_hit", 2);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
